// File: rtl/hpi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hpi_bus_arbiter
// Purpose  : Shares the CY7C67200 HPI between the Nios PIO bridge (port 0)
//            and the keyboard poller (port 1). Generates cs_n / r_n / w_n
//            timing and runs the chip-reset sequence after system reset.
// Options  : HPI_ARB_RR_EN - round-robin tie-break (default: port 0 wins)
// Revision : 1.0 - initial release
// ============================================================================
module hpi_bus_arbiter #(
  parameter int SETUP_CYCLES    = 1,
  parameter int ACCESS_CYCLES   = 4,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVER_CYCLES  = 2,
  parameter int CHIP_RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  hpi_addr,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_cs_n,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_reset_n
);

  // Counter reload values: each timed state counts down from N-1 to 0.
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] ACCESS_LD  = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYCLES - 1);
  // Chip reset counts up from the reset value 0 to this terminal value.
  localparam logic [7:0] CHIP_RST_LAST = 8'(CHIP_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_CHIP_RST = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SETUP    = 3'd2,
    ST_ACCESS   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_RECOVER  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        cs_n_q, cs_n_d;
  logic        r_n_q, r_n_d;
  logic        w_n_q, w_n_d;
  logic        rst_n_q, rst_n_d;
  logic        grant_sel;

`ifdef HPI_ARB_RR_EN
  logic        last_owner_q, last_owner_d;
`endif

  // Arbitration: picks the port to serve when leaving IDLE.
  always_comb begin
    grant_sel = 1'b0;
    if (req0 && req1) begin
`ifdef HPI_ARB_RR_EN
      grant_sel = ~last_owner_q;
`else
      grant_sel = 1'b0;
`endif
    end else if (req1) begin
      grant_sel = 1'b1;
    end
  end

  // Next-state and next-output logic; pins are computed from the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    cs_n_d  = cs_n_q;
    r_n_d   = r_n_q;
    w_n_d   = w_n_q;
    rst_n_d = rst_n_q;
`ifdef HPI_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ST_CHIP_RST: begin
        if (cnt_q == CHIP_RST_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          owner_d = grant_sel;
          we_d    = grant_sel ? we1 : we0;
          addr_d  = grant_sel ? addr1 : addr0;
          dout_d  = grant_sel ? wdata1 : wdata0;
          oe_d    = grant_sel ? we1 : we0;
          cs_n_d  = 1'b0;
`ifdef HPI_ARB_RR_EN
          last_owner_d = grant_sel;
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_ACCESS;
          cnt_d   = ACCESS_LD;
          w_n_d   = ~we_q;
          r_n_d   = we_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          r_n_d   = 1'b1;
          w_n_d   = 1'b1;
          if (!we_q) rdata_d = hpi_data_in;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOVER_LD;
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_CHIP_RST;
        cnt_d   = 8'd0;
        rst_n_d = 1'b0;
        cs_n_d  = 1'b1;
        r_n_d   = 1'b1;
        w_n_d   = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CHIP_RST;
      cnt_q   <= 8'd0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= 16'd0;
      busy_q  <= 1'b1;
      addr_q  <= 2'd0;
      dout_q  <= 16'd0;
      oe_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      r_n_q   <= 1'b1;
      w_n_q   <= 1'b1;
      rst_n_q <= 1'b0;
`ifdef HPI_ARB_RR_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      cs_n_q  <= cs_n_d;
      r_n_q   <= r_n_d;
      w_n_q   <= w_n_d;
      rst_n_q <= rst_n_d;
`ifdef HPI_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign hpi_addr     = addr_q;
  assign hpi_data_out = dout_q;
  assign hpi_data_oe  = oe_q;
  assign hpi_cs_n     = cs_n_q;
  assign hpi_r_n      = r_n_q;
  assign hpi_w_n      = w_n_q;
  assign hpi_reset_n  = rst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_hpi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hpi_bus_arbiter
// Purpose  : Directed self-checking bench for hpi_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hpi_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        we0, we1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        busy;
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] hpi_data_in;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n;
  logic [15:0] chip_val;

  int total = 0;
  int bad   = 0;

  // Capture statistics from the most recent run_capture call.
  int n_rst_low, n_cs_low, n_r_low, n_w_low, n_oe_hi, n_ack0, n_ack1;
  int first_rst_hi, first_cs, first_ack0, first_ack1, ack_in_rst, cs_bad;
  int ack_idx[2];
  int ack_port[2];
  logic [15:0] rdata_at_ack0, rdata_at_ack1, rdata_last;
  logic busy_last;
  logic exp_valid;
  logic [1:0] exp_addr;
  logic [15:0] exp_dout;
  logic exp_oe;

  hpi_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .hpi_addr(hpi_addr), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
    .hpi_data_in(hpi_data_in),
    .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
    .hpi_reset_n(hpi_reset_n)
  );

  // Chip model: drives read data only while the read strobe is low.
  assign hpi_data_in = hpi_r_n ? 16'hDEAD : chip_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples n cycles at the negedge; index 0 is the current cycle.
  // mode 1: drop a port's req on its ack; mode 2: drop both on the second ack.
  task automatic run_capture(input int n, input int mode);
    int acks;
    acks = 0;
    n_rst_low = 0; n_cs_low = 0; n_r_low = 0; n_w_low = 0; n_oe_hi = 0;
    n_ack0 = 0; n_ack1 = 0; first_rst_hi = -1; first_cs = -1;
    first_ack0 = -1; first_ack1 = -1; ack_in_rst = 0; cs_bad = 0;
    ack_idx[0] = -1; ack_idx[1] = -1; ack_port[0] = -1; ack_port[1] = -1;
    rdata_at_ack0 = 16'hxxxx; rdata_at_ack1 = 16'hxxxx;
    for (int i = 0; i < n; i++) begin
      if (!hpi_reset_n) n_rst_low++;
      if (!hpi_reset_n && (ack0 || ack1)) ack_in_rst++;
      if (hpi_reset_n && first_rst_hi < 0) first_rst_hi = i;
      if (!hpi_cs_n) begin
        n_cs_low++;
        if (first_cs < 0) first_cs = i;
        if (exp_valid && (hpi_addr !== exp_addr || hpi_data_out !== exp_dout ||
                          hpi_data_oe !== exp_oe)) cs_bad++;
      end
      if (!hpi_r_n) n_r_low++;
      if (!hpi_w_n) n_w_low++;
      if (hpi_data_oe) n_oe_hi++;
      if (ack0) begin
        n_ack0++;
        if (first_ack0 < 0) begin first_ack0 = i; rdata_at_ack0 = rdata; end
      end
      if (ack1) begin
        n_ack1++;
        if (first_ack1 < 0) begin first_ack1 = i; rdata_at_ack1 = rdata; end
      end
      if (ack0 || ack1) begin
        if (acks < 2) begin
          ack_idx[acks]  = i;
          ack_port[acks] = ack1 ? 1 : 0;
        end
        acks++;
      end
      if (mode == 1) begin
        if (ack0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
      end
      if (mode == 2 && acks >= 2) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      rdata_last = rdata;
      busy_last  = busy;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 2'd0; addr1 = 2'd0;
    wdata0 = 16'd0; wdata1 = 16'd0;
    we0 = 1'b0; we1 = 1'b0;
    chip_val = 16'h0000;
    exp_valid = 1'b0; exp_addr = 2'd0; exp_dout = 16'd0; exp_oe = 1'b0;
    tick();
    tick();

    // Reset values.
    chk("rst_reset_n", hpi_reset_n, 0);
    chk("rst_cs_n", hpi_cs_n, 1);
    chk("rst_r_n", hpi_r_n, 1);
    chk("rst_w_n", hpi_w_n, 1);
    chk("rst_addr", hpi_addr, 0);
    chk("rst_dout", hpi_data_out, 0);
    chk("rst_oe", hpi_data_oe, 0);
    chk("rst_acks", {ack0, ack1}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 1);

    // Init sequence with port 0 write pending from cycle 0.
    reset = 1'b0;
    req0 = 1'b1; addr0 = 2'd2; wdata0 = 16'h1234; we0 = 1'b1;
    exp_valid = 1'b1; exp_addr = 2'd2; exp_dout = 16'h1234; exp_oe = 1'b1;
    run_capture(40, 1);
    chk("init_rst_low_cycles", n_rst_low, 16);
    chk("init_idle_entry", first_rst_hi, 16);
    chk("init_no_ack_in_rst", ack_in_rst, 0);
    chk("wr_first_cs_fall", first_cs, 17);
    chk("wr_cs_low_cycles", n_cs_low, 6);
    chk("wr_w_low_cycles", n_w_low, 4);
    chk("wr_r_low_cycles", n_r_low, 0);
    chk("wr_pins_during_cs", cs_bad, 0);
    chk("wr_ack0_cycle", first_ack0, 23);
    chk("wr_ack0_count", n_ack0, 1);
    chk("wr_ack1_count", n_ack1, 0);
    chk("wr_busy_end", busy_last, 0);

    // Port 1 read.
    req1 = 1'b1; addr1 = 2'd0; we1 = 1'b0; chip_val = 16'hBEEF;
    exp_valid = 1'b1; exp_addr = 2'd0; exp_dout = 16'h0000; exp_oe = 1'b0;
    exp_valid = 1'b0;
    run_capture(12, 1);
    chk("rd_r_low_cycles", n_r_low, 4);
    chk("rd_w_low_cycles", n_w_low, 0);
    chk("rd_oe_high_cycles", n_oe_hi, 0);
    chk("rd_cs_low_cycles", n_cs_low, 6);
    chk("rd_ack1_cycle", first_ack1, 7);
    chk("rd_ack0_count", n_ack0, 0);
    chk("rd_rdata_at_ack", rdata_at_ack1, 16'hBEEF);

    // Subsequent write must not disturb rdata.
    req0 = 1'b1; addr0 = 2'd1; wdata0 = 16'h5555; we0 = 1'b1; chip_val = 16'h0000;
    exp_valid = 1'b1; exp_addr = 2'd1; exp_dout = 16'h5555; exp_oe = 1'b1;
    run_capture(12, 1);
    chk("wr2_ack0_cycle", first_ack0, 7);
    chk("wr2_pins_during_cs", cs_bad, 0);
    chk("wr2_rdata_kept", rdata_last, 16'hBEEF);

    // Both requests held for two transactions.
    req0 = 1'b1; addr0 = 2'd3; wdata0 = 16'hAAAA; we0 = 1'b1;
    req1 = 1'b1; addr1 = 2'd0; we1 = 1'b0; chip_val = 16'h1111;
    exp_valid = 1'b0;
    run_capture(24, 2);
    chk("tie_first_ack_cycle", ack_idx[0], 7);
    chk("tie_first_ack_port", ack_port[0], 0);
    chk("tie_second_ack_cycle", ack_idx[1], 16);
`ifdef HPI_ARB_RR_EN
    chk("tie_second_ack_port", ack_port[1], 1);
`else
    chk("tie_second_ack_port", ack_port[1], 0);
`endif
    chk("tie_cs_low_cycles", n_cs_low, 12);

    // Reset during the third ACCESS cycle of a port 0 read.
    req0 = 1'b1; addr0 = 2'd3; we0 = 1'b0; chip_val = 16'h0F0F;
    tick(); tick(); tick(); tick();
    chk("mid_pre_r_n", hpi_r_n, 0);
    reset = 1'b1;
    tick();
    chk("mid_cs_n", hpi_cs_n, 1);
    chk("mid_r_n", hpi_r_n, 1);
    chk("mid_w_n", hpi_w_n, 1);
    chk("mid_reset_n", hpi_reset_n, 0);
    chk("mid_no_ack", {ack0, ack1}, 0);
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    run_capture(32, 1);
    chk("mid_rst_low_cycles", n_rst_low, 16);
    chk("mid_ack0_cycle", first_ack0, 23);
    chk("mid_ack0_count", n_ack0, 1);
    chk("mid_rdata", rdata_at_ack0, 16'h0F0F);

    // req0 dropped during SETUP.
    req0 = 1'b1; addr0 = 2'd1; wdata0 = 16'h7777; we0 = 1'b1;
    tick();
    req0 = 1'b0;
    exp_valid = 1'b1; exp_addr = 2'd1; exp_dout = 16'h7777; exp_oe = 1'b1;
    run_capture(16, 0);
    chk("drop_ack0_cycle", first_ack0, 6);
    chk("drop_ack0_count", n_ack0, 1);
    chk("drop_cs_low_cycles", n_cs_low, 6);
    chk("drop_pins_during_cs", cs_bad, 0);
    chk("drop_busy_end", busy_last, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
